// File: rtl/serial_word_loader_pkg.sv
// Shared types and helpers for the serial word loader: FSM state encoding
// and the bit-count width derived from the word width.
package serial_word_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Modulo-WIDTH bit counter. Clear restarts the count, counting the current
// bit when enable is also high.
module bit_counter
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = count_width(WIDTH)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign terminal = enable && (count == LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? CW'(1) : '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word assembler with frame sync, one-cycle LOAD strobe
// for the downstream register, and truncation (framing error) reporting.
module serial_word_loader
  import serial_word_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SIN,
  input  logic             SVALID,
  input  logic             SYNC,
  output logic [WIDTH-1:0] DOUT,
  output logic             LOAD,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  logic [WIDTH-2:0] sreg;
  logic [WIDTH-2:0] sreg_base;
  logic [WIDTH-1:0] word;
  logic [WIDTH-2:0] shifted;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             count_en;

  // Bits only count once a frame has started (or starts this very cycle).
  assign count_en = SVALID && (SYNC || (state == SHIFT));

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .clear    (SYNC),
    .enable   (count_en),
    .count    (count),
    .terminal (terminal)
  );

  // The register holds at most WIDTH-1 bits; the current bit completes the word.
  assign sreg_base = SYNC ? '0 : sreg;
  assign word      = MSB_FIRST ? {sreg_base, SIN} : {SIN, sreg_base};
  assign shifted   = MSB_FIRST ? word[WIDTH-2:0] : word[WIDTH-1:1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      sreg      <= '0;
      DOUT      <= '0;
      LOAD      <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      LOAD      <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (SYNC) begin
        // SYNC overrides a completing bit: that bit starts the new frame.
        state     <= SHIFT;
        FRAME_ERR <= (state == SHIFT) && (count != '0);
        BUSY      <= SVALID;
        sreg      <= SVALID ? shifted : '0;
      end else if ((state == SHIFT) && SVALID) begin
        if (terminal) begin
          DOUT <= word;
          LOAD <= 1'b1;
          sreg <= '0;
          BUSY <= 1'b0;
        end else begin
          sreg <= shifted;
          BUSY <= 1'b1;
        end
      end
    end
  end

endmodule
